// File: rtl/fb_pkg.sv
// ---------------------------------------------------------------------------
// fb_pkg
// Frame-buffer constants shared by the frame-buffer write controller and the
// VGA memory reader, plus the write-controller state encoding.
//   FB_ADDR_W : frame-buffer address width (640x480 pixels fit in 19 bits)
//   FB_DATA_W : pixel width, RGB444
//   FB_DEPTH  : number of pixels in one frame
// ---------------------------------------------------------------------------
package fb_pkg;

  localparam int          FB_ADDR_W = 19;
  localparam int          FB_DATA_W = 12;
  localparam int unsigned FB_DEPTH  = 307200;

  // Port A ownership: IDLE = requesters arbitrate, CLEAR = fill sequencer.
  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } fb_state_t;

endpackage : fb_pkg

// File: rtl/fb_wr_ctrl_if.sv
// ---------------------------------------------------------------------------
// fb_req_if / fb_ram_if
// Bus bundles for the frame-buffer write controller.
//   fb_req_if : one pixel-write requester (valid/addr/data in, ready out).
//               master = requester side, slave = controller side.
//               Transfer when valid & ready; addr/data held stable until then.
//   fb_ram_if : bRAM port A write bus (ena, wea, addra, dina).
//               master = controller side, slave = bRAM side.
// ---------------------------------------------------------------------------
interface fb_req_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 12
);
  logic              valid;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              ready;

  modport master (output valid, addr, data, input ready);
  modport slave  (input valid, addr, data, output ready);
endinterface : fb_req_if

interface fb_ram_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 12
);
  logic              ena;
  logic              wea;
  logic [ADDR_W-1:0] addra;
  logic [DATA_W-1:0] dina;

  modport master (output ena, wea, addra, dina);
  modport slave  (input ena, wea, addra, dina);
endinterface : fb_ram_if

// File: rtl/fb_wr_ctrl_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin grant. The grant is combinational from allow, valid
// and the pointer; the pointer moves only when a grant is issued (a grant
// always means a transfer, since grant implies valid).
//   clk, rst : clock, asynchronous active-high reset
//   allow    : arbitration permitted this cycle
//   valid[1:0] : request lines
//   grant[1:0] : one-hot (or zero) grant, equal to the ready outputs
// ---------------------------------------------------------------------------
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       allow,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  // 0: requester 0 wins a tie, 1: requester 1 wins a tie.
  logic prio_reg;

  always_comb begin
    grant = 2'b00;
    if (allow) begin
      unique case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = prio_reg ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  // After serving requester 0 the tie goes to requester 1, and vice versa.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_reg <= 1'b0;
    end else if (|grant) begin
      prio_reg <= grant[0];
    end
  end

endmodule : rr_arb2

// File: rtl/fb_wr_ctrl.sv
// ---------------------------------------------------------------------------
// fb_wr_ctrl
// Owns bRAM port A of the frame buffer. Two pixel-write requesters share the
// port with round-robin arbitration; a clear sequencer can fill the whole
// buffer (addresses 0..DEPTH-1) with one colour. With VBLANK_GATE=1, all
// writes and clear progress are restricted to vblank=1 cycles.
// Ports:
//   clk, rst     : pixel clock, asynchronous active-high reset
//   vblank       : vertical blanking (used only when VBLANK_GATE=1)
//   clear_start  : one-cycle pulse starting a clear
//   clear_color  : fill colour, sampled when clear_start is accepted
//   clear_busy   : clear sequencer owns port A
//   clear_done   : pulse coincident with the final clear write on ram
//   req0, req1   : requester buses (fb_req_if.slave)
//   ram          : bRAM port A (fb_ram_if.master), registered, 1-cycle latency
// ---------------------------------------------------------------------------
module fb_wr_ctrl
  import fb_pkg::*;
#(
  parameter int          ADDR_W      = FB_ADDR_W,
  parameter int          DATA_W      = FB_DATA_W,
  parameter int unsigned DEPTH       = FB_DEPTH,
  parameter bit          VBLANK_GATE = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vblank,
  input  logic              clear_start,
  input  logic [DATA_W-1:0] clear_color,
  output logic              clear_busy,
  output logic              clear_done,
  fb_req_if.slave           req0,
  fb_req_if.slave           req1,
  fb_ram_if.master          ram
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  fb_state_t         state_reg, state_next;
  logic [ADDR_W-1:0] cnt_reg,   cnt_next;
  logic [DATA_W-1:0] color_reg, color_next;
  logic              busy_reg,  busy_next;
  logic              done_reg,  done_next;
  logic              wr_reg,    wr_next;
  logic [ADDR_W-1:0] addr_reg,  addr_next;
  logic [DATA_W-1:0] data_reg,  data_next;

  logic       en;
  logic       start_acc;
  logic       arb_allow;
  logic [1:0] grant;

  assign en = !VBLANK_GATE || vblank;

  // busy_reg stays high for one cycle after the last clear step (state is
  // already IDLE then), so both clear acceptance and arbitration wait for it.
  assign start_acc = clear_start && (state_reg == IDLE) && !busy_reg;
  assign arb_allow = (state_reg == IDLE) && !busy_reg && en && !clear_start;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .allow (arb_allow),
    .valid ({req1.valid, req0.valid}),
    .grant (grant)
  );

  assign req0.ready = grant[0];
  assign req1.ready = grant[1];

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    color_next = color_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    wr_next    = 1'b0;
    addr_next  = addr_reg;
    data_next  = data_reg;

    // clear_done is visible this cycle; busy drops on the next one.
    if (done_reg) begin
      busy_next = 1'b0;
    end

    unique case (state_reg)
      IDLE: begin
        if (start_acc) begin
          state_next = CLEAR;
          cnt_next   = '0;
          color_next = clear_color;
          busy_next  = 1'b1;
        end else if (grant[0]) begin
          wr_next   = 1'b1;
          addr_next = req0.addr;
          data_next = req0.data;
        end else if (grant[1]) begin
          wr_next   = 1'b1;
          addr_next = req1.addr;
          data_next = req1.data;
        end
      end
      CLEAR: begin
        if (en) begin
          wr_next   = 1'b1;
          addr_next = cnt_reg;
          data_next = color_reg;
          if (cnt_reg == LAST_ADDR) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            cnt_next = cnt_reg + ADDR_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      color_reg <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      wr_reg    <= 1'b0;
      addr_reg  <= '0;
      data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      color_reg <= color_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      wr_reg    <= wr_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
    end
  end

  assign ram.ena    = wr_reg;
  assign ram.wea    = wr_reg;
  assign ram.addra  = addr_reg;
  assign ram.dina   = data_reg;
  assign clear_busy = busy_reg;
  assign clear_done = done_reg;

endmodule : fb_wr_ctrl
